// File: rtl/lsu_pkg.sv
// Shared types and helpers for the handshaked load/store unit.
// Sizes, FSM states, captured-request record and the alignment rule live here.
package lsu_pkg;

    // Widest lane offset (64-bit bus); narrower buses mask the top bit off.
    localparam int LANE_BITS = 3;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W,
        SZ_D
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } lsu_state_e;

    typedef struct packed {
        logic                 we;
        lsu_size_e            size;
        logic                 is_unsigned;
        logic [LANE_BITS-1:0] off;
        logic [4:0]           rd;
    } lsu_req_t;

    typedef struct packed {
        logic misaligned;
        logic timeout;
    } lsu_rsp_t;

    // A dword access is only legal on a 64-bit bus.
    function automatic logic lsu_misaligned(input lsu_size_e size,
                                            input logic [2:0] addr_lo,
                                            input logic       wide_bus);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return addr_lo[0];
            SZ_W:    return |addr_lo[1:0];
            default: return !wide_bus || (|addr_lo);
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store shift and byte mask, load extract and extend.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  lsu_size_e                   size,
    input  logic [LANE_BITS-1:0]        off,
    input  logic                        is_unsigned,
    input  logic [DATA_WIDTH-1:0]       wdata,
    output logic [DATA_WIDTH-1:0]       wdata_lane,
    output logic [DATA_WIDTH/8-1:0]     mask,
    input  logic [DATA_WIDTH-1:0]       rdata,
    output logic [DATA_WIDTH-1:0]       rdata_ext
);

    localparam int NB = DATA_WIDTH / 8;

    logic [LANE_BITS-1:0]  lane;
    logic [LANE_BITS+2:0]  shamt;
    logic [NB-1:0]         base;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] keep;
    logic                  sign;

    always_comb begin
        lane       = off & LANE_BITS'(NB - 1);
        shamt      = {lane, 3'b000};
        wdata_lane = wdata << shamt;
        shifted    = rdata >> shamt;
        case (size)
            SZ_B: begin
                base = NB'(1);
                keep = DATA_WIDTH'(8'hFF);
                sign = shifted[7];
            end
            SZ_H: begin
                base = NB'(3);
                keep = DATA_WIDTH'(16'hFFFF);
                sign = shifted[15];
            end
            SZ_W: begin
                base = NB'(15);
                keep = DATA_WIDTH'(32'hFFFF_FFFF);
                sign = shifted[31];
            end
            default: begin
                base = '1;
                keep = '1;
                sign = 1'b0;
            end
        endcase
        mask = base << lane;
        // Full-width loads get keep = all ones, so the sign fill vanishes.
        rdata_ext = (shifted & keep) | ({DATA_WIDTH{sign & ~is_unsigned}} & ~keep);
    end

endmodule

// File: rtl/lsu_hs.sv
// MEM-stage load/store unit driving a req/gnt/rvalid memory port.
// Holds the pipeline via stall until the access responds, errors or times out.
module lsu_hs
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic                    req_valid,
    input  logic                    req_we,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [4:0]              req_rd,
    output logic                    stall,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [4:0]              rsp_rd,
    output logic                    err_misaligned,
    output logic                    err_timeout,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_mask,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int LB    = $clog2(NB);
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e             state, next;
    lsu_req_t               req_in, cap;
    lsu_rsp_t               err_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q, rdata_q;
    logic [NB-1:0]          mask_q;
    logic [CNT_W-1:0]       cnt;
    logic                   misaligned, terminal;

    lsu_size_e              al_size;
    logic [LANE_BITS-1:0]   al_off;
    logic                   al_uns;
    logic [DATA_WIDTH-1:0]  al_wdata, al_rdata;
    logic [NB-1:0]          al_mask;

    always_comb begin
        req_in.we          = req_we;
        req_in.size        = lsu_size_e'(req_size);
        req_in.is_unsigned = req_unsigned;
        req_in.off         = LANE_BITS'(req_addr[LB-1:0]);
        req_in.rd          = req_rd;
    end

    assign misaligned = lsu_misaligned(req_in.size, req_addr[2:0], DATA_WIDTH == 64);
    assign terminal   = (cnt == CNT_LAST);

    // Stores are steered from the live request in IDLE; loads use the captured fields.
    assign al_size = (state == IDLE) ? req_in.size        : cap.size;
    assign al_off  = (state == IDLE) ? req_in.off         : cap.off;
    assign al_uns  = (state == IDLE) ? req_in.is_unsigned : cap.is_unsigned;

    lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .size        (al_size),
        .off         (al_off),
        .is_unsigned (al_uns),
        .wdata       (req_wdata),
        .wdata_lane  (al_wdata),
        .mask        (al_mask),
        .rdata       (mem_rdata),
        .rdata_ext   (al_rdata)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state <= IDLE;
        else         state <= next;
    end

    // gnt and rvalid are tested before the terminal count so they win a tie.
    always_comb begin
        next = state;
        case (state)
            IDLE: if (req_valid) next = misaligned ? DONE : REQ;
            REQ: begin
                if (mem_gnt)       next = cap.we ? DONE : RESP;
                else if (terminal) next = DONE;
            end
            RESP: begin
                if (mem_rvalid)    next = DONE;
                else if (terminal) next = DONE;
            end
            DONE: next = IDLE;
        endcase
    end

    always_comb begin
        mem_req        = (state == REQ);
        rsp_valid      = (state == DONE);
        stall          = arst_n && ((state == REQ) || (state == RESP) ||
                                    ((state == IDLE) && req_valid));
        rsp_rdata      = rsp_valid ? rdata_q : '0;
        rsp_rd         = rsp_valid ? cap.rd  : '0;
        err_misaligned = rsp_valid && err_q.misaligned;
        err_timeout    = rsp_valid && err_q.timeout;
        mem_we         = cap.we;
        mem_addr       = addr_q;
        mem_wdata      = wdata_q;
        mem_mask       = mask_q;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cap     <= '0;
            err_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            rdata_q <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    cap     <= req_in;
                    addr_q  <= {req_addr[ADDR_WIDTH-1:LB], {LB{1'b0}}};
                    wdata_q <= al_wdata;
                    mask_q  <= req_we ? al_mask : '1;
                    rdata_q <= '0;
                    err_q   <= '{misaligned: misaligned, timeout: 1'b0};
                    cnt     <= '0;
                end
                REQ: begin
                    if (mem_gnt) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (terminal) err_q.timeout <= 1'b1;
                    end
                end
                RESP: begin
                    if (mem_rvalid) begin
                        rdata_q <= al_rdata;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (terminal) err_q.timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
